// File: rtl/stage_if.sv
// +-----------------------------------------------------------------------------+
// | stage_if : instruction fetch stage, Wishbone B4 classic master, 1-entry skid |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module stage_if #(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic [31:0] iwbm_addr_o,
   output logic        iwbm_cyc_o,
   output logic        iwbm_stb_o,
   input  logic [31:0] iwbm_dat_i,
   input  logic        iwbm_ack_i,
   input  logic        iwbm_err_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   output logic        e_inst_addr_misaligned_o,
   output logic        e_inst_access_fault_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_SKID  = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        cyc_q, cyc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pco_q, pco_d;
   logic        valid_q, valid_d;
   logic        emis_q, emis_d;
   logic        eacc_q, eacc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        skid_err_q, skid_err_d;

   logic w_free;
   logic w_ack;
   logic w_err;
   logic w_redir_mis;

   assign w_free      = !valid_q || !stall_i;
   assign w_ack       = cyc_q && iwbm_ack_i;
   assign w_err       = cyc_q && iwbm_err_i && !iwbm_ack_i;
   assign w_redir_mis = (redirect_pc_i[1:0] != 2'b00);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cyc_d        = cyc_q;
      instr_d      = instr_q;
      pco_d        = pco_q;
      valid_d      = valid_q;
      emis_d       = emis_q;
      eacc_d       = eacc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_err_d   = skid_err_q;

      if (redirect_i) begin
         pc_d       = redirect_pc_i;
         skid_err_d = 1'b0;
         eacc_d     = 1'b0;
         instr_d    = NOP_INST;
         if (w_redir_mis) begin
            pco_d   = redirect_pc_i;
            valid_d = 1'b1;
            emis_d  = 1'b1;
         end else begin
            valid_d = 1'b0;
            emis_d  = 1'b0;
         end
         // A live transaction cannot be abandoned on the bus; finish it silently.
         if (cyc_q && !iwbm_ack_i && !iwbm_err_i) begin
            state_d = S_DRAIN;
            cyc_d   = 1'b1;
         end else if (w_redir_mis) begin
            state_d = S_HALT;
            cyc_d   = 1'b0;
         end else begin
            state_d = S_FETCH;
            cyc_d   = 1'b1;
         end
      end else begin
         if (state_q != S_SKID && w_free) begin
            valid_d = 1'b0;
            instr_d = NOP_INST;
            emis_d  = 1'b0;
            eacc_d  = 1'b0;
         end
         case (state_q)
            S_FETCH: begin
               if (w_ack) begin
                  pc_d = pc_q + 32'd4;
                  if (w_free) begin
                     instr_d = iwbm_dat_i;
                     pco_d   = pc_q;
                     valid_d = 1'b1;
                  end else begin
                     skid_instr_d = iwbm_dat_i;
                     skid_pc_d    = pc_q;
                     skid_err_d   = 1'b0;
                     cyc_d        = 1'b0;
                     state_d      = S_SKID;
                  end
               end else if (w_err) begin
                  cyc_d = 1'b0;
                  if (w_free) begin
                     instr_d = NOP_INST;
                     pco_d   = pc_q;
                     valid_d = 1'b1;
                     eacc_d  = 1'b1;
                     state_d = S_HALT;
                  end else begin
                     skid_instr_d = NOP_INST;
                     skid_pc_d    = pc_q;
                     skid_err_d   = 1'b1;
                     state_d      = S_SKID;
                  end
               end else if (!cyc_q) begin
                  cyc_d = 1'b1;
               end
            end
            S_SKID: begin
               if (!stall_i) begin
                  instr_d = skid_instr_q;
                  pco_d   = skid_pc_q;
                  valid_d = 1'b1;
                  emis_d  = 1'b0;
                  eacc_d  = skid_err_q;
                  cyc_d   = !skid_err_q;
                  state_d = skid_err_q ? S_HALT : S_FETCH;
               end
            end
            S_DRAIN: begin
               // pc_q already holds the redirect target; its alignment picks the exit.
               if (iwbm_ack_i || iwbm_err_i) begin
                  cyc_d   = (pc_q[1:0] == 2'b00);
                  state_d = (pc_q[1:0] == 2'b00) ? S_FETCH : S_HALT;
               end
            end
            default: begin
               cyc_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_ADDR;
         cyc_q        <= 1'b0;
         instr_q      <= NOP_INST;
         pco_q        <= RESET_ADDR;
         valid_q      <= 1'b0;
         emis_q       <= 1'b0;
         eacc_q       <= 1'b0;
         skid_instr_q <= NOP_INST;
         skid_pc_q    <= RESET_ADDR;
         skid_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cyc_q        <= cyc_d;
         instr_q      <= instr_d;
         pco_q        <= pco_d;
         valid_q      <= valid_d;
         emis_q       <= emis_d;
         eacc_q       <= eacc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_err_q   <= skid_err_d;
      end
   end

   assign iwbm_addr_o              = pc_q;
   assign iwbm_cyc_o               = cyc_q;
   assign iwbm_stb_o               = cyc_q;
   assign instruction_o            = instr_q;
   assign pc_o                     = pco_q;
   assign valid_o                  = valid_q;
   assign e_inst_addr_misaligned_o = emis_q;
   assign e_inst_access_fault_o    = eacc_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_if.sv
// +-----------------------------------------------------------------------------+
// | tb_stage_if : directed vector bench for stage_if                            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_stage_if;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RA  = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] addr;
   logic        cyc, stb;
   logic [31:0] dat;
   logic        ack = 1'b0, err = 1'b0, stall = 1'b0, redir = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic [31:0] instr, pco;
   logic        valid, emis, eacc;

   int n_checks = 0;
   int n_err    = 0;

   // Memory model: each word reads back as {addr[15:0], C0DE}.
   assign dat = {addr[15:0], 16'hC0DE};

   always #5 clk = ~clk;

   stage_if dut (
      .clk_i                    (clk),
      .rstn_i                   (rstn),
      .iwbm_addr_o              (addr),
      .iwbm_cyc_o               (cyc),
      .iwbm_stb_o               (stb),
      .iwbm_dat_i               (dat),
      .iwbm_ack_i               (ack),
      .iwbm_err_i               (err),
      .stall_i                  (stall),
      .redirect_i               (redir),
      .redirect_pc_i            (rpc),
      .instruction_o            (instr),
      .pc_o                     (pco),
      .valid_o                  (valid),
      .e_inst_addr_misaligned_o (emis),
      .e_inst_access_fault_o    (eacc)
   );

   typedef struct {
      logic        stall, ack, err, redir;
      logic [31:0] rpc;
      logic        cyc;
      logic        ca;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc, instr;
      logic        emis, eacc;
   } vec_t;

   vec_t vt[$];

   task automatic v(input logic s, a, e, r, input logic [31:0] rp,
                    input logic c, ca, input logic [31:0] ad,
                    input logic vl, input logic [31:0] p, ins, input logic em, ea);
      vec_t x;
      x.stall = s; x.ack = a; x.err = e; x.redir = r; x.rpc = rp;
      x.cyc = c; x.ca = ca; x.addr = ad; x.valid = vl; x.pc = p; x.instr = ins;
      x.emis = em; x.eacc = ea;
      vt.push_back(x);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      // stall ack err redir rpc | cyc ca addr valid pc instr emis eacc
      v(0,0,0,0,0,            1,1,32'h8000_0000, 0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0004, 1,32'h8000_0000, 32'h0000_C0DE,0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0008, 1,32'h8000_0004, 32'h0004_C0DE,0,0);
      v(0,1,0,0,0,            1,1,32'h8000_000C, 1,32'h8000_0008, 32'h0008_C0DE,0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0010, 1,32'h8000_000C, 32'h000C_C0DE,0,0);
      v(1,1,0,0,0,            0,1,32'h8000_0014, 1,32'h8000_000C, 32'h000C_C0DE,0,0);
      v(1,0,0,0,0,            0,1,32'h8000_0014, 1,32'h8000_000C, 32'h000C_C0DE,0,0);
      v(1,0,0,0,0,            0,1,32'h8000_0014, 1,32'h8000_000C, 32'h000C_C0DE,0,0);
      v(0,0,0,0,0,            1,1,32'h8000_0014, 1,32'h8000_0010, 32'h0010_C0DE,0,0);
      v(0,0,0,0,0,            1,1,32'h8000_0014, 0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0018, 1,32'h8000_0014, 32'h0014_C0DE,0,0);
      v(1,0,0,0,0,            1,1,32'h8000_0018, 1,32'h8000_0014, 32'h0014_C0DE,0,0);
      v(0,0,0,1,32'h8000_0100,1,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,0,0,0,0,            1,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0100, 0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0104, 1,32'h8000_0100, 32'h0100_C0DE,0,0);
      v(0,1,0,1,32'h8000_0102,0,0,32'h0,         1,32'h8000_0102, NOP,          1,0);
      v(1,0,0,0,0,            0,0,32'h0,         1,32'h8000_0102, NOP,          1,0);
      v(0,0,0,0,0,            0,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,0,0,0,0,            0,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0008,1,1,32'h8000_0008, 0,32'h0,         NOP,          0,0);
      v(0,0,1,0,0,            0,1,32'h8000_0008, 1,32'h8000_0008, NOP,          0,1);
      v(1,0,0,0,0,            0,1,32'h8000_0008, 1,32'h8000_0008, NOP,          0,1);
      v(0,0,0,0,0,            0,1,32'h8000_0008, 0,32'h0,         NOP,          0,0);
      v(0,0,0,0,0,            0,1,32'h8000_0008, 0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0200,1,1,32'h8000_0200, 0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0301,1,0,32'h0,         1,32'h8000_0301, NOP,          1,0);
      v(1,1,0,0,0,            0,0,32'h0,         1,32'h8000_0301, NOP,          1,0);
      v(0,0,0,0,0,            0,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0400,1,1,32'h8000_0400, 0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0500,1,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,0,0,1,32'h8000_0600,1,0,32'h0,         0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0600, 0,32'h0,         NOP,          0,0);
      v(0,1,0,0,0,            1,1,32'h8000_0604, 1,32'h8000_0600, 32'h0600_C0DE,0,0);
      v(1,0,1,0,0,            0,1,32'h8000_0604, 1,32'h8000_0600, 32'h0600_C0DE,0,0);
      v(0,0,0,0,0,            0,1,32'h8000_0604, 1,32'h8000_0604, NOP,          0,1);
      v(0,0,0,0,0,            0,1,32'h8000_0604, 0,32'h0,         NOP,          0,0);

      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc",   -1, {31'b0, cyc},   32'd0);
      chk("rst_stb",   -1, {31'b0, stb},   32'd0);
      chk("rst_addr",  -1, addr,           RA);
      chk("rst_valid", -1, {31'b0, valid}, 32'd0);
      chk("rst_pc",    -1, pco,            RA);
      chk("rst_instr", -1, instr,          NOP);
      chk("rst_exc",   -1, {30'b0, emis, eacc}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         stall = vt[i].stall; ack = vt[i].ack; err = vt[i].err;
         redir = vt[i].redir; rpc = vt[i].rpc;
         @(posedge clk);
         #1;
         chk("cyc",   i, {31'b0, cyc},   {31'b0, vt[i].cyc});
         chk("stb",   i, {31'b0, stb},   {31'b0, vt[i].cyc});
         if (vt[i].ca) chk("addr", i, addr, vt[i].addr);
         chk("valid", i, {31'b0, valid}, {31'b0, vt[i].valid});
         if (vt[i].valid) chk("pc", i, pco, vt[i].pc);
         chk("instr", i, instr,          vt[i].instr);
         chk("emis",  i, {31'b0, emis},  {31'b0, vt[i].emis});
         chk("eacc",  i, {31'b0, eacc},  {31'b0, vt[i].eacc});
      end

      // Address wrap at the top of the address space.
      @(negedge clk);
      stall = 0; ack = 0; err = 0; redir = 1; rpc = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      chk("wrap_req_addr", 100, addr, 32'hFFFF_FFFC);
      chk("wrap_req_cyc",  100, {31'b0, cyc}, 32'd1);
      @(negedge clk);
      redir = 0; ack = 1;
      @(posedge clk); #1;
      chk("wrap_next_addr", 101, addr,  32'h0000_0000);
      chk("wrap_pc",        101, pco,   32'hFFFF_FFFC);
      chk("wrap_instr",     101, instr, 32'hFFFC_C0DE);
      chk("wrap_cyc",       101, {31'b0, cyc}, 32'd1);

      // Asynchronous reset in the middle of a bus transaction.
      @(negedge clk);
      ack = 0;
      #2 rstn = 1'b0;
      #1;
      chk("arst_cyc",   102, {31'b0, cyc},   32'd0);
      chk("arst_valid", 102, {31'b0, valid}, 32'd0);
      chk("arst_addr",  102, addr,           RA);
      chk("arst_instr", 102, instr,          NOP);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("rel_cyc",  103, {31'b0, cyc}, 32'd1);
      chk("rel_addr", 103, addr,         RA);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
